// File: rtl/i2c_slave.sv
// I2C target with a single 7-bit address. SCL/SDA are oversampled on clk, SDA is
// open-drain, write bytes are pushed to an RX FIFO and read bytes are popped from a TX FIFO.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       i2c_reset_n,
    input  logic       i2c_scl,
    inout  wire        i2c_sda,
    input  logic [7:0] i2c_data_in,
    input  logic       fifo_tx_empty,
    output logic       fifo_tx_rd_en,
    output logic [7:0] i2c_data_out,
    input  logic       fifo_rx_full,
    output logic       fifo_rx_wr_en,
    output logic       i2c_busy
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        RX_DATA,
        RX_ACK,
        TX_DATA,
        TX_ACK,
        WAIT_STOP
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  tx_q, tx_d;
    logic        rw_q, rw_d;
    logic        phase_q, phase_d;
    logic        sda_oe_q, sda_oe_d;
    logic        busy_q, busy_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        rd_en_q, rd_en_d;
    logic        wr_en_q, wr_en_d;
    logic        cap_q, cap_d;

    // One extra stage beyond the synchronizer holds the previous synced value for edge detection.
    logic [SYNC_STAGES:0] scl_sync_q;
    logic [SYNC_STAGES:0] sda_sync_q;

    always_ff @(posedge clk or negedge i2c_reset_n) begin
        if (!i2c_reset_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-1:0], i2c_scl};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-1:0], i2c_sda};
        end
    end

    logic scl_s, scl_p, sda_s, sda_p;
    logic scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] shifted;

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign scl_p     = scl_sync_q[SYNC_STAGES];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign sda_p     = sda_sync_q[SYNC_STAGES];
    assign scl_rise  = scl_s & ~scl_p;
    assign scl_fall  = ~scl_s & scl_p;
    assign start_det = scl_s & scl_p & sda_p & ~sda_s & ~sda_oe_q;
    assign stop_det  = scl_s & scl_p & ~sda_p & sda_s & ~sda_oe_q;
    assign shifted   = {shift_q[6:0], sda_s};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        rw_d       = rw_q;
        phase_d    = phase_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        data_out_d = data_out_q;
        rd_en_d    = 1'b0;
        wr_en_d    = 1'b0;
        cap_d      = rd_en_q;

        // FIFO read data arrives one clk after the pop pulse.
        if (cap_q) begin
            tx_d = i2c_data_in;
        end

        if (start_det) begin
            state_d  = ADDR;
            cnt_d    = 3'd7;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (stop_det) begin
            state_d  = IDLE;
            cnt_d    = 3'd0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                end
                ADDR: begin
                    if (scl_rise) begin
                        shift_d = shifted;
                        if (cnt_q == 3'd0) begin
                            if (shifted[7:1] == SLAVE_ADDR) begin
                                state_d = ADDR_ACK;
                                busy_d  = 1'b1;
                                rw_d    = shifted[0];
                                phase_d = 1'b0;
                                if (shifted[0]) begin
                                    if (!fifo_tx_empty) rd_en_d = 1'b1;
                                    else                tx_d    = 8'hFF;
                                end
                            end else begin
                                state_d = WAIT_STOP;
                            end
                        end else begin
                            cnt_d = cnt_q - 3'd1;
                        end
                    end
                end
                ADDR_ACK, RX_ACK: begin
                    // First fall opens the ACK slot, second fall closes it.
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            cnt_d = 3'd7;
                            if (state_q == ADDR_ACK && rw_q) begin
                                sda_oe_d = ~tx_q[7];
                                state_d  = TX_DATA;
                            end else begin
                                sda_oe_d = 1'b0;
                                state_d  = RX_DATA;
                            end
                        end
                    end
                end
                RX_DATA: begin
                    if (scl_rise) begin
                        shift_d = shifted;
                        if (cnt_q == 3'd0) begin
                            data_out_d = shifted;
                            if (!fifo_rx_full) begin
                                wr_en_d = 1'b1;
                                state_d = RX_ACK;
                                phase_d = 1'b0;
                            end else begin
                                state_d = WAIT_STOP;
                                busy_d  = 1'b0;
                            end
                        end else begin
                            cnt_d = cnt_q - 3'd1;
                        end
                    end
                end
                TX_DATA: begin
                    if (scl_fall) begin
                        if (cnt_q == 3'd0) begin
                            sda_oe_d = 1'b0;
                            state_d  = TX_ACK;
                            phase_d  = 1'b0;
                        end else begin
                            cnt_d    = cnt_q - 3'd1;
                            sda_oe_d = ~tx_q[cnt_q - 3'd1];
                        end
                    end
                end
                TX_ACK: begin
                    if (scl_rise && !phase_q) begin
                        if (!sda_s) begin
                            phase_d = 1'b1;
                            if (!fifo_tx_empty) rd_en_d = 1'b1;
                            else                tx_d    = 8'hFF;
                        end else begin
                            state_d = WAIT_STOP;
                            busy_d  = 1'b0;
                        end
                    end else if (scl_fall && phase_q) begin
                        sda_oe_d = ~tx_q[7];
                        cnt_d    = 3'd7;
                        state_d  = TX_DATA;
                    end
                end
                WAIT_STOP: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d  = IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge i2c_reset_n) begin
        if (!i2c_reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            shift_q    <= 8'd0;
            tx_q       <= 8'd0;
            rw_q       <= 1'b0;
            phase_q    <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            data_out_q <= 8'd0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            cap_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            rw_q       <= rw_d;
            phase_q    <= phase_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            data_out_q <= data_out_d;
            rd_en_q    <= rd_en_d;
            wr_en_q    <= wr_en_d;
            cap_q      <= cap_d;
        end
    end

    assign i2c_sda       = sda_oe_q ? 1'b0 : 1'bz;
    assign fifo_tx_rd_en = rd_en_q;
    assign fifo_rx_wr_en = wr_en_q;
    assign i2c_data_out  = data_out_q;
    assign i2c_busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-banged I2C master drives table-driven transactions against
// FIFO models; a reset-during-read sequence is written out by hand.
module tb_i2c_slave;

    localparam int Q = 40;  // quarter SCL period (4 clk periods)

    typedef enum logic [3:0] {
        OP_START, OP_STOP, OP_WR, OP_RD, OP_TXLOAD, OP_FULL, OP_CLR,
        OP_BUSY, OP_RXCHK, OP_CNT, OP_NODRV, OP_SDAHI
    } op_e;

    typedef struct {
        op_e        op;
        logic [7:0] data;  // byte sent / loaded / expected push count
        logic       flag;  // master ACK bit on reads (1 = NACK), rx_full level
        logic [7:0] exp;   // expected ACK bit, read byte, busy, or pop count
    } vec_t;

    logic       clk = 1'b0;
    logic       i2c_reset_n = 1'b1;
    logic       scl = 1'b1;
    logic       m_oe = 1'b0;
    wire        sda_bus;
    logic [7:0] i2c_data_in;
    logic       fifo_tx_empty;
    logic       fifo_tx_rd_en;
    logic [7:0] i2c_data_out;
    logic       fifo_rx_full = 1'b0;
    logic       fifo_rx_wr_en;
    logic       i2c_busy;

    assign sda_bus = m_oe ? 1'b0 : 1'bz;
    pullup (sda_bus);

    always #5 clk = ~clk;

    i2c_slave #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .i2c_reset_n  (i2c_reset_n),
        .i2c_scl      (scl),
        .i2c_sda      (sda_bus),
        .i2c_data_in  (i2c_data_in),
        .fifo_tx_empty(fifo_tx_empty),
        .fifo_tx_rd_en(fifo_tx_rd_en),
        .i2c_data_out (i2c_data_out),
        .fifo_rx_full (fifo_rx_full),
        .fifo_rx_wr_en(fifo_rx_wr_en),
        .i2c_busy     (i2c_busy)
    );

    // TX FIFO model: data valid one clk after the pop pulse.
    logic [7:0] tx_mem [16];
    int tx_wr = 0;
    int tx_rd = 0;
    int pop_cnt = 0;
    assign fifo_tx_empty = (tx_wr == tx_rd);

    always @(posedge clk) begin
        if (fifo_tx_rd_en) begin
            pop_cnt <= pop_cnt + 1;
            if (tx_rd != tx_wr) begin
                i2c_data_in <= tx_mem[tx_rd % 16];
                tx_rd       <= tx_rd + 1;
            end
        end
    end

    // RX capture and bus monitors, sampled on the falling clk edge.
    logic [7:0] rx_mem [16];
    int rx_wr = 0;
    int push_cnt = 0;
    int low_cnt = 0;
    int viol_cnt = 0;
    logic wr_prev = 1'b0;
    logic rd_prev = 1'b0;

    always @(negedge clk) begin
        if (fifo_rx_wr_en) begin
            rx_mem[rx_wr % 16] <= i2c_data_out;
            rx_wr              <= rx_wr + 1;
            push_cnt           <= push_cnt + 1;
        end
        if (!m_oe && sda_bus == 1'b0) low_cnt <= low_cnt + 1;
        if ((fifo_rx_wr_en && wr_prev) || (fifo_tx_rd_en && rd_prev)) viol_cnt <= viol_cnt + 1;
        wr_prev <= fifo_rx_wr_en;
        rd_prev <= fifo_tx_rd_en;
    end

    int errors = 0;
    int checks = 0;
    int rx_rd = 0;
    int push_base = 0;
    int pop_base = 0;
    int low_base = 0;
    vec_t vecs[$];

    function automatic void add(op_e op, logic [7:0] data, logic flag, logic [7:0] exp);
        vec_t v;
        v.op   = op;
        v.data = data;
        v.flag = flag;
        v.exp  = exp;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        #(Q); m_oe = ~b;
        #(Q); scl = 1'b1;
        #(2*Q); scl = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        #(Q); m_oe = 1'b0;
        #(Q); scl = 1'b1;
        #(Q); b = sda_bus;
        #(Q); scl = 1'b0;
    endtask

    task automatic i2c_start();
        #(Q); m_oe = 1'b0;
        #(Q); scl = 1'b1;
        #(2*Q); m_oe = 1'b1;
        #(2*Q); scl = 1'b0;
    endtask

    task automatic i2c_stop();
        #(Q); m_oe = 1'b1;
        #(Q); scl = 1'b1;
        #(2*Q); m_oe = 1'b0;
        #(2*Q);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic       b;
        logic [7:0] got;
        $display("vec %0d %s data=%02h flag=%0d exp=%02h", idx, v.op.name(), v.data, v.flag, v.exp);
        case (v.op)
            OP_START: i2c_start();
            OP_STOP:  i2c_stop();
            OP_WR: begin
                for (int i = 7; i >= 0; i--) send_bit(v.data[i]);
                recv_bit(b);
                check($sformatf("v%0d_ack", idx), {31'd0, b}, {31'd0, v.exp[0]});
            end
            OP_RD: begin
                got = 8'h00;
                for (int i = 7; i >= 0; i--) begin
                    recv_bit(b);
                    got[i] = b;
                end
                send_bit(v.flag);
                check($sformatf("v%0d_rd_data", idx), {24'd0, got}, {24'd0, v.exp});
            end
            OP_TXLOAD: begin
                tx_mem[tx_wr % 16] = v.data;
                tx_wr++;
            end
            OP_FULL: fifo_rx_full = v.flag;
            OP_CLR: begin
                push_base = push_cnt;
                pop_base  = pop_cnt;
                low_base  = low_cnt;
            end
            OP_BUSY: check($sformatf("v%0d_busy", idx), {31'd0, i2c_busy}, {31'd0, v.exp[0]});
            OP_RXCHK: begin
                if (rx_rd != rx_wr) begin
                    got = rx_mem[rx_rd % 16];
                    rx_rd++;
                    check($sformatf("v%0d_rx_byte", idx), {24'd0, got}, {24'd0, v.exp});
                end else begin
                    check($sformatf("v%0d_rx_avail", idx), 32'(rx_wr - rx_rd), 32'd1);
                end
            end
            OP_CNT: begin
                check($sformatf("v%0d_pushes", idx), 32'(push_cnt - push_base), {24'd0, v.data});
                check($sformatf("v%0d_pops", idx), 32'(pop_cnt - pop_base), {24'd0, v.exp});
            end
            OP_NODRV: check($sformatf("v%0d_slave_low_clks", idx), 32'(low_cnt - low_base), 32'd0);
            OP_SDAHI: check($sformatf("v%0d_sda_released", idx), {31'd0, sda_bus}, 32'd1);
            default: ;
        endcase
    endtask

    initial begin
        // Write 0x3C, 0xC3 to 0x50
        add(OP_CLR, 0, 0, 0);     add(OP_START, 0, 0, 0);   add(OP_WR, 8'hA0, 0, 0);
        add(OP_BUSY, 0, 0, 1);    add(OP_WR, 8'h3C, 0, 0);  add(OP_WR, 8'hC3, 0, 0);
        add(OP_BUSY, 0, 0, 1);    add(OP_STOP, 0, 0, 0);    add(OP_BUSY, 0, 0, 0);
        add(OP_RXCHK, 0, 0, 8'h3C); add(OP_RXCHK, 0, 0, 8'hC3); add(OP_CNT, 2, 0, 0);
        // Read 0x5A, 0xA5 with ACK then NACK
        add(OP_TXLOAD, 8'h5A, 0, 0); add(OP_TXLOAD, 8'hA5, 0, 0); add(OP_CLR, 0, 0, 0);
        add(OP_START, 0, 0, 0);   add(OP_WR, 8'hA1, 0, 0);  add(OP_BUSY, 0, 0, 1);
        add(OP_RD, 0, 0, 8'h5A);  add(OP_RD, 0, 1, 8'hA5);  add(OP_SDAHI, 0, 0, 0);
        add(OP_BUSY, 0, 0, 0);    add(OP_STOP, 0, 0, 0);    add(OP_CNT, 0, 0, 2);
        // Address mismatch
        add(OP_CLR, 0, 0, 0);     add(OP_START, 0, 0, 0);   add(OP_WR, 8'hA2, 0, 1);
        add(OP_BUSY, 0, 0, 0);    add(OP_WR, 8'h11, 0, 1);  add(OP_STOP, 0, 0, 0);
        add(OP_NODRV, 0, 0, 0);   add(OP_CNT, 0, 0, 0);     add(OP_BUSY, 0, 0, 0);
        // RX FIFO full on second byte
        add(OP_CLR, 0, 0, 0);     add(OP_START, 0, 0, 0);   add(OP_WR, 8'hA0, 0, 0);
        add(OP_WR, 8'h66, 0, 0);  add(OP_FULL, 0, 1, 0);    add(OP_WR, 8'h99, 0, 1);
        add(OP_BUSY, 0, 0, 0);    add(OP_STOP, 0, 0, 0);    add(OP_FULL, 0, 0, 0);
        add(OP_RXCHK, 0, 0, 8'h66); add(OP_CNT, 1, 0, 0);
        // Read with TX FIFO empty
        add(OP_CLR, 0, 0, 0);     add(OP_START, 0, 0, 0);   add(OP_WR, 8'hA1, 0, 0);
        add(OP_RD, 0, 1, 8'hFF);  add(OP_STOP, 0, 0, 0);    add(OP_CNT, 0, 0, 0);
        // Write, repeated START, read
        add(OP_TXLOAD, 8'h3E, 0, 0); add(OP_CLR, 0, 0, 0);  add(OP_START, 0, 0, 0);
        add(OP_WR, 8'hA0, 0, 0);  add(OP_WR, 8'h07, 0, 0);  add(OP_START, 0, 0, 0);
        add(OP_BUSY, 0, 0, 0);    add(OP_WR, 8'hA1, 0, 0);  add(OP_RD, 0, 1, 8'h3E);
        add(OP_STOP, 0, 0, 0);    add(OP_RXCHK, 0, 0, 8'h07); add(OP_CNT, 1, 0, 1);

        #3 i2c_reset_n = 1'b0;
        #20;
        check("reset_busy", {31'd0, i2c_busy}, 32'd0);
        check("reset_rd_en", {31'd0, fifo_tx_rd_en}, 32'd0);
        check("reset_wr_en", {31'd0, fifo_rx_wr_en}, 32'd0);
        check("reset_data_out", {24'd0, i2c_data_out}, 32'd0);
        check("reset_sda", {31'd0, sda_bus}, 32'd1);
        @(negedge clk);
        i2c_reset_n = 1'b1;
        #(4*Q);

        for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

        // Reset while the slave holds SDA low for a 0 data bit
        run_vec(900, '{OP_TXLOAD, 8'h00, 1'b0, 8'h00});
        run_vec(901, '{OP_START, 8'h00, 1'b0, 8'h00});
        run_vec(902, '{OP_WR, 8'hA1, 1'b0, 8'h00});
        #(Q);
        $display("seq reset: slave driving bit7 of 0x00, asserting reset");
        check("pre_reset_sda_low", {31'd0, sda_bus}, 32'd0);
        check("pre_reset_busy", {31'd0, i2c_busy}, 32'd1);
        @(negedge clk);
        #2 i2c_reset_n = 1'b0;
        #1;
        check("mid_reset_sda", {31'd0, sda_bus}, 32'd1);
        check("mid_reset_busy", {31'd0, i2c_busy}, 32'd0);
        check("mid_reset_data_out", {24'd0, i2c_data_out}, 32'd0);
        #(4*Q);
        @(negedge clk);
        i2c_reset_n = 1'b1;
        #(Q); scl = 1'b1;
        #(4*Q);
        run_vec(903, '{OP_CLR, 8'h00, 1'b0, 8'h00});
        run_vec(904, '{OP_START, 8'h00, 1'b0, 8'h00});
        run_vec(905, '{OP_WR, 8'hA0, 1'b0, 8'h00});
        run_vec(906, '{OP_WR, 8'h42, 1'b0, 8'h00});
        run_vec(907, '{OP_STOP, 8'h00, 1'b0, 8'h00});
        run_vec(908, '{OP_RXCHK, 8'h00, 1'b0, 8'h42});
        run_vec(909, '{OP_CNT, 8'd1, 1'b0, 8'd0});

        #(4*Q);
        check("fifo_pulse_width_violations", 32'(viol_cnt), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
